rvx_skid_slice: RTL and testbench



---
 rtl/rvx_misc_pkg.sv | 9 +
 rtl/rvx_skid_slice.sv | 61 ++++++
 tb/tb_rvx_skid_slice.sv | 139 +++++++++++++
 3 files changed

// File: rtl/rvx_misc_pkg.sv
// rvx_misc_pkg: shared state encodings and widths for the misc library blocks
package rvx_misc_pkg;
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_BUSY  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;
  localparam int BW_COUNT = 2;
endpackage

// File: rtl/rvx_skid_slice.sv
// rvx_skid_slice: two-entry valid/ready register slice cutting data, valid and ready paths
module rvx_skid_slice
  import rvx_misc_pkg::*;
#(
  parameter int                 BW_DATA    = 32,
  parameter logic [BW_DATA-1:0] RESET_DATA = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [BW_DATA-1:0]  s_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [BW_DATA-1:0]  m_data,
  output logic [BW_COUNT-1:0] count
);
  skid_state_e state, state_n;
  logic [BW_DATA-1:0] main_q, main_n, skid_q, skid_n;
  logic s_fire, m_fire;
  assign s_ready = (state != SKID_FULL) & ~rst & ~flush;
  assign m_valid = state != SKID_EMPTY;
  assign m_data  = main_q;
  assign count   = BW_COUNT'(state);
  assign s_fire  = s_valid & s_ready;
  assign m_fire  = m_valid & m_ready;
  always_comb begin
    state_n = state;
    main_n  = main_q;
    skid_n  = skid_q;
    case (state)
      SKID_EMPTY: begin
        main_n  = s_fire ? s_data : main_q;
        state_n = s_fire ? SKID_BUSY : SKID_EMPTY;
      end
      SKID_BUSY: begin
        main_n  = (s_fire & m_fire) ? s_data : main_q;
        skid_n  = (s_fire & ~m_fire) ? s_data : skid_q;
        state_n = (s_fire & ~m_fire) ? SKID_FULL : (m_fire & ~s_fire) ? SKID_EMPTY : SKID_BUSY;
      end
      SKID_FULL: begin
        main_n  = m_fire ? skid_q : main_q;
        state_n = m_fire ? SKID_BUSY : SKID_FULL;
      end
      default: state_n = SKID_EMPTY;
    endcase
  end
  // flush clears exactly like reset; any same-cycle m_fire already consumed the old m_data
  always_ff @(posedge clk) begin
    if (rst | flush) begin
      state  <= SKID_EMPTY;
      main_q <= RESET_DATA;
      skid_q <= RESET_DATA;
    end else begin
      state  <= state_n;
      main_q <= main_n;
      skid_q <= skid_n;
    end
  end
endmodule

// File: tb/tb_rvx_skid_slice.sv
// tb_rvx_skid_slice: randomized and directed check of the skid slice against a queue model
module tb_rvx_skid_slice;
  localparam int BW = 16;
  localparam logic [BW-1:0] RST_VAL = 16'hDEAD;
  logic clk, rst, flush, s_valid, s_ready, m_valid, m_ready;
  logic [BW-1:0] s_data, m_data;
  logic [1:0] count;
  int tests = 0;
  int fails = 0;
  logic [BW-1:0] q[$];
  logic [BW-1:0] hold;
  bit started = 0;

  rvx_skid_slice #(.BW_DATA(BW), .RESET_DATA(RST_VAL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .count(count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // model: an ordered queue of held words; the head is what m_data must show
  always @(posedge clk) begin
    if (rst || flush) begin
      q.delete();
      hold <= RST_VAL;
      started <= 1;
    end else if (s_valid && q.size() < 2) begin
      if (m_ready && q.size() > 0) hold <= q.pop_front();
      q.push_back(s_data);
    end else if (m_ready && q.size() > 0) begin
      hold <= q.pop_front();
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("m_valid", 32'(m_valid), 32'(q.size() > 0));
      check("count", 32'(count), 32'(q.size()));
      check("s_ready", 32'(s_ready), 32'(q.size() < 2 && !rst && !flush));
      check("m_data", 32'(m_data), 32'(q.size() > 0 ? q[0] : hold));
    end
  end

  initial begin
    rst = 1; flush = 0; s_valid = 1; s_data = 16'hAAAA; m_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_s_ready", 32'(s_ready), 0);
      check("rst_m_valid", 32'(m_valid), 0);
      check("rst_count", 32'(count), 0);
    end
    check("rst_m_data", 32'(m_data), 32'hDEAD);
    rst = 0; m_ready = 1;
    for (int i = 1; i <= 20; i++) begin
      s_data = BW'(i);
      step();
      check("stream_data", 32'(m_data), 32'(i));
      check("stream_count", 32'(count), 1);
    end
    s_valid = 0;
    step();
    check("stream_drain", 32'(count), 0);
    m_ready = 0; s_valid = 1; s_data = 16'h11;
    step();
    check("fill1_count", 32'(count), 1);
    check("fill1_s_ready", 32'(s_ready), 1);
    s_data = 16'h22;
    step();
    check("fill2_count", 32'(count), 2);
    check("fill2_s_ready", 32'(s_ready), 0);
    s_data = 16'h99;
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_data", 32'(m_data), 32'h11);
      check("stall_valid", 32'(m_valid), 1);
      check("stall_s_ready", 32'(s_ready), 0);
    end
    s_valid = 0; m_ready = 1;
    step();
    check("drain1_data", 32'(m_data), 32'h22);
    check("drain1_count", 32'(count), 1);
    step();
    check("drain2_count", 32'(count), 0);
    check("drain2_s_ready", 32'(s_ready), 1);
    m_ready = 0; s_valid = 1; s_data = 16'h33;
    step();
    s_data = 16'h44;
    step();
    check("refill_count", 32'(count), 2);
    flush = 1; s_data = 16'h55;
    #1;
    check("flush_s_ready", 32'(s_ready), 0);
    step();
    check("flush_count", 32'(count), 0);
    check("flush_valid", 32'(m_valid), 0);
    check("flush_data", 32'(m_data), 32'hDEAD);
    flush = 0; s_valid = 0; m_ready = 1;
    step();
    check("post_flush_count", 32'(count), 0);
    check("post_flush_data", 32'(m_data), 32'hDEAD);
    for (int i = 0; i < 10000; i++) begin
      rst = ($urandom_range(0, 255) == 0);
      flush = ($urandom_range(0, 63) == 0);
      s_valid = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      s_data = BW'($urandom_range(0, 255));
      @(negedge clk);
      #2;
      begin
        logic r;
        r = s_ready;
        m_ready = ~m_ready;
        #1;
        check("s_ready_vs_m_ready", 32'(s_ready), 32'(r));
        m_ready = ~m_ready;
      end
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
